// File: rtl/cache_mem_arbiter.sv
// Memory-side controller for the icache/dcache pair: arbitrates with dcache priority
// and a bounded icache starvation guard, and sequences each word access against RAM latency.
module cache_mem_arbiter #(
    parameter int ISTARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    localparam int SW = $clog2(ISTARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(ISTARVE_MAX);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t          state, next_state;
    logic [SW-1:0]   dstreak, dstreak_next;
    logic            memerr_q;
    logic            err_seen;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            dstreak  <= '0;
            memerr_q <= 1'b0;
        end else begin
            state    <= next_state;
            dstreak  <= dstreak_next;
            memerr_q <= memerr_q | err_seen;
        end
    end

    // The error flag is visible in the very cycle the RAM first reports ERROR.
    assign memerr = memerr_q | err_seen;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        next_state   = state;
        dstreak_next = dstreak;
        err_seen     = 1'b0;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        case (state)
            IDLE: begin
                if (dstreak == STREAK_MAX && iREN)
                    next_state = IACC;
                else if (dWEN || dREN)
                    next_state = DACC;
                else if (iREN)
                    next_state = IACC;
            end

            IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    iwait        = 1'b0;
                    iload        = ramload;
                    next_state   = IDLE;
                    dstreak_next = '0;
                end else if (ramstate == RAM_ERROR) begin
                    err_seen = 1'b1;
                end
            end

            DACC: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!(dWEN || dREN)) begin
                    next_state = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    dwait      = 1'b0;
                    dload      = dWEN ? '0 : ramload;
                    next_state = IDLE;
                    // Count dcache wins only while the icache is actually waiting.
                    if (!iREN)
                        dstreak_next = '0;
                    else if (dstreak != STREAK_MAX)
                        dstreak_next = dstreak + SW'(1);
                end else if (ramstate == RAM_ERROR) begin
                    err_seen = 1'b1;
                end
            end

            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: table-driven single accesses, hand-written
// corner sequences, and randomized cache traffic checked against a memory/fairness model.
module tb_cache_mem_arbiter;

    localparam int ISTARVE_MAX = 4;
    localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACCESS = 2'd2, S_ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN, memerr;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    cache_mem_arbiter #(.ISTARVE_MAX(ISTARVE_MAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    // Background RAM content for never-written words.
    function automatic logic [31:0] bg(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // RAM model: err_n ERROR cycles, then lat BUSY cycles, then ACCESS.
    logic [31:0] ram_mem [1024];
    bit          ram_written [1024];
    int          lat = 0, err_n = 0, busy_cnt = 0, err_cnt = 0;
    logic        ram_en;

    assign ram_en = ramREN | ramWEN;

    always_comb begin
        if (!ram_en)                ramstate = S_FREE;
        else if (err_cnt < err_n)   ramstate = S_ERROR;
        else if (busy_cnt < lat)    ramstate = S_BUSY;
        else                        ramstate = S_ACCESS;
    end

    always_comb begin
        ramload = ram_written[ramaddr[9:0]] ? ram_mem[ramaddr[9:0]] : bg(ramaddr);
    end

    always @(posedge CLK) begin
        if (!ram_en) begin
            busy_cnt <= 0;
            err_cnt  <= 0;
        end else if (ramstate == S_ACCESS) begin
            busy_cnt <= 0;
            err_cnt  <= 0;
            if (ramWEN) begin
                ram_mem[ramaddr[9:0]]     <= ramstore;
                ram_written[ramaddr[9:0]] <= 1'b1;
            end
        end else if (ramstate == S_ERROR) begin
            err_cnt <= err_cnt + 1;
        end else begin
            busy_cnt <= busy_cnt + 1;
        end
    end

    // Reference memory as the caches should see it.
    logic [31:0] mdl [1024];
    bit          mdl_w [1024];

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        return mdl_w[a[9:0]] ? mdl[a[9:0]] : bg(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        lat = 0; err_n = 0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic drop_all();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    endtask

    // Counts cycles (starting with the current one) until the chosen wait goes low; -1 on timeout.
    task automatic wait_done(input bit is_i, output int cyc, output int en_cnt);
        cyc = 0;
        en_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge CLK);
            #1;
            cyc++;
            if (ramREN || ramWEN) en_cnt++;
            if ((is_i ? iwait : dwait) == 1'b0) return;
        end
        cyc = -1;
    endtask

    typedef struct {
        bit          ir, dr, dw;
        logic [31:0] addr, wdata;
        int          lat;
        int          exp_cyc, exp_en;
        bit          exp_wen;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[8];

    initial begin
        forever begin
            #500000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
        end
    end

    initial begin
        int cyc, en_cnt;
        int n_d_before;
        bit got_i;
        bit i_cmp, d_cmp;
        int streak, i_pend, n_i, n_d, r;

        vecs[0] = '{0, 0, 1, 32'h40,  32'hDEADBEEF, 0, 2, 1, 1, 32'h0};
        vecs[1] = '{1, 0, 0, 32'h40,  32'h0,        2, 4, 3, 0, 32'hDEADBEEF};
        vecs[2] = '{0, 1, 1, 32'h100, 32'h12345678, 0, 2, 1, 1, 32'h0};
        vecs[3] = '{0, 1, 0, 32'h100, 32'h0,        1, 3, 2, 0, 32'h12345678};
        vecs[4] = '{1, 0, 0, 32'h100, 32'h0,        0, 2, 1, 0, 32'h12345678};
        vecs[5] = '{0, 1, 0, 32'h7,   32'h0,        3, 5, 4, 0, bg(32'h7)};
        vecs[6] = '{0, 0, 1, 32'h7,   32'hCAFEF00D, 1, 3, 2, 1, 32'h0};
        vecs[7] = '{1, 0, 0, 32'h7,   32'h0,        0, 2, 1, 0, 32'hCAFEF00D};

        // Reset state, with requests already asserted.
        nRST = 1'b0;
        iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
        iaddr = 32'h11; daddr = 32'h55; dstore = 32'hFFFF_FFFF;
        #3;
        check("reset ramREN", ramREN, 1'b0);
        check("reset ramWEN", ramWEN, 1'b0);
        check("reset iwait", iwait, 1'b1);
        check("reset dwait", dwait, 1'b1);
        check("reset ramaddr", ramaddr, 32'h0);
        check("reset ramstore", ramstore, 32'h0);
        check("reset iload", iload, 32'h0);
        check("reset memerr", memerr, 1'b0);
        do_reset();

        // Single accesses from the table.
        for (int v = 0; v < 8; v++) begin
            @(negedge CLK);
            lat = vecs[v].lat;
            iREN = vecs[v].ir; dREN = vecs[v].dr; dWEN = vecs[v].dw;
            iaddr = vecs[v].addr; daddr = vecs[v].addr; dstore = vecs[v].wdata;
            wait_done(vecs[v].ir, cyc, en_cnt);
            check($sformatf("vec%0d cycles", v), cyc, vecs[v].exp_cyc);
            check($sformatf("vec%0d enable cycles", v), en_cnt, vecs[v].exp_en);
            check($sformatf("vec%0d ramWEN", v), ramWEN, vecs[v].exp_wen);
            check($sformatf("vec%0d ramREN", v), ramREN, !vecs[v].exp_wen);
            check($sformatf("vec%0d load", v), vecs[v].ir ? iload : dload, vecs[v].exp_load);
            check($sformatf("vec%0d other wait", v), vecs[v].ir ? dwait : iwait, 1'b1);
            if (vecs[v].dw) check($sformatf("vec%0d ramstore", v), ramstore, vecs[v].wdata);
            @(negedge CLK);
            drop_all();
        end

        // Simultaneous requests, zero-latency RAM: dcache first, icache two cycles later.
        do_reset();
        @(negedge CLK);
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h40; daddr = 32'h100;
        #1;
        check("simul arb cycle dwait", dwait, 1'b1);
        check("simul arb cycle ramREN", ramREN, 1'b0);
        @(negedge CLK); #1;
        check("simul dwait", dwait, 1'b0);
        check("simul iwait during d", iwait, 1'b1);
        check("simul dload", dload, 32'h12345678);
        @(negedge CLK);
        dREN = 1'b0;
        #1;
        check("simul gap iwait", iwait, 1'b1);
        @(negedge CLK); #1;
        check("simul iwait", iwait, 1'b0);
        check("simul iload", iload, 32'hDEADBEEF);
        @(negedge CLK);
        drop_all();
        #1;
        check("simul dstreak cleared", 32'(dut.dstreak), 32'd0);

        // Starvation guard: dcache held continuously while icache waits.
        do_reset();
        @(negedge CLK);
        iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; daddr = 32'h40;
        n_d_before = 0;
        got_i = 1'b0;
        for (int c = 0; c < 40 && !got_i; c++) begin
            if (c > 0) @(negedge CLK);
            #1;
            if (!dwait) n_d_before++;
            if (!iwait) got_i = 1'b1;
        end
        check("starve icache served", got_i, 1'b1);
        check("starve dcache count", n_d_before, ISTARVE_MAX);
        @(negedge CLK);
        iREN = 1'b0;
        #1;
        check("starve dstreak after icache", 32'(dut.dstreak), 32'd0);
        repeat (2) @(negedge CLK);
        #1;
        check("starve dstreak with icache idle", 32'(dut.dstreak), 32'd0);
        drop_all();

        // ERROR for three cycles, then ACCESS.
        do_reset();
        @(negedge CLK);
        err_n = 3; lat = 0; dREN = 1'b1; daddr = 32'h7;
        #1;
        check("err arb memerr", memerr, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); #1;
            check($sformatf("err cycle%0d dwait", k), dwait, 1'b1);
            check($sformatf("err cycle%0d memerr", k), memerr, 1'b1);
        end
        @(negedge CLK); #1;
        check("err recovery dwait", dwait, 1'b0);
        check("err recovery dload", dload, 32'hCAFEF00D);
        @(negedge CLK);
        drop_all();
        err_n = 0;
        #1;
        check("err memerr sticky", memerr, 1'b1);

        // Request withdrawn while the RAM is busy.
        do_reset();
        check("abort memerr cleared by reset", memerr, 1'b0);
        @(negedge CLK);
        lat = 5; dREN = 1'b1; daddr = 32'h7;
        repeat (2) @(negedge CLK);
        dREN = 1'b0;
        #1;
        check("abort dwait", dwait, 1'b1);
        check("abort ramREN", ramREN, 1'b0);
        @(negedge CLK); #1;
        check("abort after dwait", dwait, 1'b1);
        @(negedge CLK);
        lat = 0; dREN = 1'b1;
        wait_done(1'b0, cyc, en_cnt);
        check("abort next access cycles", cyc, 2);
        @(negedge CLK);
        drop_all();

        // Reset falling mid-IACC after an ERROR set memerr.
        @(negedge CLK);
        lat = 5; err_n = 1; iREN = 1'b1; iaddr = 32'h40;
        repeat (2) @(negedge CLK);
        #1;
        check("rst-mid memerr before", memerr, 1'b1);
        check("rst-mid ramREN before", ramREN, 1'b1);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check("rst-mid ramREN", ramREN, 1'b0);
        check("rst-mid iwait", iwait, 1'b1);
        check("rst-mid memerr", memerr, 1'b0);
        check("rst-mid ramaddr", ramaddr, 32'h0);
        do_reset();

        // Randomized traffic against the reference memory and fairness bound.
        i_cmp = 1'b0; d_cmp = 1'b0;
        streak = 0; i_pend = 0; n_i = 0; n_d = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (!ram_en) lat = $urandom_range(0, 3);
            if (!iREN || i_cmp) begin
                iREN  = ($urandom_range(0, 9) < 6);
                iaddr = 32'd512 + $urandom_range(0, 15);
            end
            if (!(dREN || dWEN) || d_cmp) begin
                r      = $urandom_range(0, 9);
                dWEN   = (r < 3);
                dREN   = (r == 0) || (r >= 3 && r < 6);
                daddr  = 32'd512 + $urandom_range(0, 15);
                dstore = $urandom;
            end
            #1;
            i_cmp = !iwait;
            d_cmp = !dwait;
            if (iREN && !i_cmp) i_pend++;
            if (i_cmp || d_cmp) check("rand single completion", i_cmp && d_cmp, 1'b0);
            if (i_cmp) begin
                check("rand iload", iload, mdl_read(iaddr));
                check("rand icache wait bound", i_pend <= 5 * (ISTARVE_MAX + 2), 1'b1);
                streak = 0;
                i_pend = 0;
                n_i++;
            end
            if (d_cmp) begin
                if (dWEN) begin
                    check("rand write dload", dload, 32'h0);
                    mdl[daddr[9:0]]   = dstore;
                    mdl_w[daddr[9:0]] = 1'b1;
                end else begin
                    check("rand dload", dload, mdl_read(daddr));
                end
                streak = iREN ? streak + 1 : 0;
                check("rand dcache streak bound", streak <= ISTARVE_MAX, 1'b1);
                n_d++;
            end
        end
        check("rand icache completions seen", n_i > 0, 1'b1);
        check("rand dcache completions seen", n_d > 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
